// File: rtl/load_align_unit.sv
// Load align unit: fetches one or two aligned words for a load, then aligns and extends the bytes.
// Latency: response visible 2 cycles after accept (single beat), 3 (split), 1 (fault).
// Backpressure: req_ready is low outside IDLE; the response is held stable until resp_ready.
module load_align_unit #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_re,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_fault
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(NB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Access size in bytes from funct3; 111 decodes to 8 but is rejected as illegal.
  function automatic logic [3:0] f_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f_size = 4'd1;
      2'b01:   f_size = 4'd2;
      2'b10:   f_size = 4'd4;
      default: f_size = 4'd8;
    endcase
  endfunction

  state_t            r_state;
  state_t            w_next_state;
  logic [OFFW-1:0]   r_offset;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_aligned;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_resp_data;
  logic              r_resp_fault;

  logic [OFFW-1:0]   w_req_offset;
  logic [XLEN-1:0]   w_req_aligned;
  logic [3:0]        w_req_size;
  logic              w_req_illegal;
  logic              w_req_misaligned;
  logic              w_req_fault;
  logic              w_accept;
  logic [3:0]        w_size;
  logic              w_split;
  logic [XLEN-1:0]   w_lo_src;
  logic [XLEN-1:0]   w_hi_src;
  logic [XLEN-1:0]   w_field;
  logic [XLEN-1:0]   w_mask;
  logic              w_sign;
  logic [XLEN-1:0]   w_result;

  // Request decode: size, legality and alignment of the incoming load.
  always_comb begin
    w_req_offset     = req_addr[OFFW-1:0];
    w_req_aligned    = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    w_req_size       = f_size(req_funct3);
    w_req_illegal    = (req_funct3 == 3'b111) ||
                       ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    w_req_misaligned = ((4'(w_req_offset) & (w_req_size - 4'd1)) != 4'd0);
    w_req_fault      = w_req_illegal || (!MISALIGN_EN && w_req_misaligned);
    w_accept         = (r_state == IDLE) && req_valid;
  end

  // Datapath for the captured load: split detection, byte alignment and extension.
  always_comb begin
    w_size  = f_size(r_funct3);
    w_split = (5'(r_offset) + 5'(w_size)) > 5'(NB);
    // In BEAT1 the low word is the captured one and the high word is arriving now.
    if (r_state == BEAT1) begin
      w_lo_src = r_lo;
      w_hi_src = mem_rdata;
    end else begin
      w_lo_src = mem_rdata;
      w_hi_src = '0;
    end
    w_field = XLEN'({w_hi_src, w_lo_src} >> {r_offset, 3'b000});
    case (w_size)
      4'd1: begin
        w_mask = XLEN'(8'hFF);
        w_sign = w_field[7];
      end
      4'd2: begin
        w_mask = XLEN'(16'hFFFF);
        w_sign = w_field[15];
      end
      4'd4: begin
        w_mask = XLEN'(32'hFFFF_FFFF);
        w_sign = w_field[31];
      end
      default: begin
        w_mask = '1;
        w_sign = w_field[XLEN-1];
      end
    endcase
    // funct3[2] selects zero-extension; a full-width mask leaves nothing to extend.
    w_result = (w_field & w_mask) | (~w_mask & {XLEN{w_sign & ~r_funct3[2]}});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (req_valid) w_next_state = w_req_fault ? RESP : BEAT0;
      BEAT0: w_next_state = w_split ? BEAT1 : RESP;
      BEAT1: w_next_state = RESP;
      RESP:  if (resp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: memory strobe only on accept or the second beat of a split load.
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
    mem_re     = 1'b0;
    mem_addr   = '0;
    if (w_accept && !w_req_fault) begin
      mem_re   = 1'b1;
      mem_addr = w_req_aligned;
    end else if ((r_state == BEAT0) && w_split) begin
      mem_re   = 1'b1;
      mem_addr = r_aligned + WORD_BYTES;
    end
  end

  // Capture request fields, memory beats and the registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_offset     <= '0;
      r_funct3     <= '0;
      r_aligned    <= '0;
      r_lo         <= '0;
      r_resp_data  <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_offset  <= w_req_offset;
            r_funct3  <= req_funct3;
            r_aligned <= w_req_aligned;
            if (w_req_fault) begin
              r_resp_data  <= '0;
              r_resp_fault <= 1'b1;
            end
          end
        end
        BEAT0: begin
          r_lo <= mem_rdata;
          if (!w_split) begin
            r_resp_data  <= w_result;
            r_resp_fault <= 1'b0;
          end
        end
        BEAT1: begin
          r_resp_data  <= w_result;
          r_resp_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_data  = r_resp_data;
  assign resp_fault = r_resp_fault;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: two instances (split-capable and aligned-only) sharing stimulus.
// Checks results, faults, latency, memory read addresses, backpressure hold and mid-load reset.
// Outputs are sampled 1ns after the rising edge; inputs are changed at the same point.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        resp_ready;

  logic        a_req_valid, a_req_ready, a_mem_re, a_resp_valid, a_resp_ready, a_resp_fault;
  logic [31:0] a_mem_addr, a_mem_rdata, a_resp_data;
  logic        b_req_valid, b_req_ready, b_mem_re, b_resp_valid, b_resp_ready, b_resp_fault;
  logic [31:0] b_mem_addr, b_mem_rdata, b_resp_data;

  logic        o_req_ready, o_mem_re, o_resp_valid, o_resp_fault;
  logic [31:0] o_mem_addr, o_resp_data;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rd_q[$];

  always #5 clk = ~clk;

  assign a_req_valid  = req_valid & ~sel;
  assign b_req_valid  = req_valid & sel;
  assign a_resp_ready = sel ? 1'b1 : resp_ready;
  assign b_resp_ready = sel ? resp_ready : 1'b1;

  assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
  assign o_mem_re     = sel ? b_mem_re     : a_mem_re;
  assign o_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
  assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign o_resp_data  = sel ? b_resp_data  : a_resp_data;
  assign o_resp_fault = sel ? b_resp_fault : a_resp_fault;

  load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .mem_re     (a_mem_re),
    .mem_addr   (a_mem_addr),
    .mem_rdata  (a_mem_rdata),
    .resp_valid (a_resp_valid),
    .resp_ready (a_resp_ready),
    .resp_data  (a_resp_data),
    .resp_fault (a_resp_fault)
  );

  load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) u_dut_na (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .mem_re     (b_mem_re),
    .mem_addr   (b_mem_addr),
    .mem_rdata  (b_mem_rdata),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_data  (b_resp_data),
    .resp_fault (b_resp_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h100: mem_word = 32'h8877_6655;
      32'h104: mem_word = 32'h4433_2211;
      default: mem_word = 32'hA5A5_A5A5;
    endcase
  endfunction

  // 1-cycle-latency data memory per instance, logging every read address.
  always @(posedge clk) begin
    a_mem_rdata <= a_mem_re ? mem_word(a_mem_addr) : 32'h0;
    b_mem_rdata <= b_mem_re ? mem_word(b_mem_addr) : 32'h0;
    if (a_mem_re) rd_q.push_back(a_mem_addr);
    if (b_mem_re) rd_q.push_back(b_mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one load with resp_ready high and check result, fault, latency and reads.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] exp_data, input logic exp_fault, input int exp_lat,
                         input int exp_nrd, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    int lat;
    rd_q.delete();
    resp_ready = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    req_valid  = 1'b1;
    chk({tag, ".req_ready"}, 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!o_resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".data"}, o_resp_data, exp_data);
    chk({tag, ".fault"}, 32'(o_resp_fault), 32'(exp_fault));
    chk({tag, ".nrd"}, 32'(rd_q.size()), 32'(exp_nrd));
    if (rd_q.size() > 0 && exp_nrd > 0) chk({tag, ".rd0"}, rd_q[0], exp_a0);
    if (rd_q.size() > 1 && exp_nrd > 1) chk({tag, ".rd1"}, rd_q[1], exp_a1);
    @(posedge clk); #1;
    chk({tag, ".idle"}, 32'({o_req_ready, o_resp_valid}), 32'b10);
  endtask

  initial begin
    reset      = 1'b1;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_funct3 = 3'b000;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready",  32'(o_req_ready),  32'd1);
    chk("rst.mem_re",     32'(o_mem_re),     32'd0);
    chk("rst.mem_addr",   o_mem_addr,        32'h0);
    chk("rst.resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst.resp_data",  o_resp_data,       32'h0);
    chk("rst.resp_fault", 32'(o_resp_fault), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Split-capable instance.
    do_load("lb103",  32'h103, 3'b000, 32'hFFFF_FF88, 1'b0, 2, 1, 32'h100, 32'h0);
    do_load("lhu103", 32'h103, 3'b101, 32'h0000_1188, 1'b0, 3, 2, 32'h100, 32'h104);
    do_load("lw102",  32'h102, 3'b010, 32'h2211_8877, 1'b0, 3, 2, 32'h100, 32'h104);
    do_load("lh102",  32'h102, 3'b001, 32'hFFFF_8877, 1'b0, 2, 1, 32'h100, 32'h0);
    do_load("lw100",  32'h100, 3'b010, 32'h8877_6655, 1'b0, 2, 1, 32'h100, 32'h0);
    do_load("lbu103", 32'h103, 3'b100, 32'h0000_0088, 1'b0, 2, 1, 32'h100, 32'h0);
    do_load("lb104",  32'h104, 3'b000, 32'h0000_0011, 1'b0, 2, 1, 32'h104, 32'h0);
    do_load("ld32",   32'h100, 3'b011, 32'h0,         1'b1, 1, 0, 32'h0,   32'h0);
    do_load("f111",   32'h100, 3'b111, 32'h0,         1'b1, 1, 0, 32'h0,   32'h0);

    // Aligned-only instance.
    sel = 1'b1;
    #1;
    do_load("na.lw102", 32'h102, 3'b010, 32'h0,         1'b1, 1, 0, 32'h0,   32'h0);
    do_load("na.f111",  32'h100, 3'b111, 32'h0,         1'b1, 1, 0, 32'h0,   32'h0);
    do_load("na.lh102", 32'h102, 3'b001, 32'hFFFF_8877, 1'b0, 2, 1, 32'h100, 32'h0);
    sel = 1'b0;
    #1;

    // Backpressure: response held for 3 stalled cycles, then released.
    resp_ready = 1'b0;
    req_addr   = 32'h100;
    req_funct3 = 3'b000;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp.valid",     32'(o_resp_valid), 32'd1);
      chk("bp.data",      o_resp_data,       32'h0000_0055);
      chk("bp.req_ready", 32'(o_req_ready),  32'd0);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release", 32'({o_req_ready, o_resp_valid}), 32'b10);

    // Reset during BEAT1 of a split load aborts it without a response.
    req_addr   = 32'h103;
    req_funct3 = 3'b101;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.req_ready",  32'(o_req_ready),  32'd1);
    chk("abort.resp_valid", 32'(o_resp_valid), 32'd0);
    chk("abort.mem_re",     32'(o_mem_re),     32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (o_resp_valid) seen++;
      end
      chk("abort.no_resp", 32'(seen), 32'd0);
    end
    do_load("lbu101", 32'h101, 3'b100, 32'h0000_0066, 1'b0, 2, 1, 32'h100, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
